countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_digit_dec.sv | 46 ++++
 rtl/countdown_timer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Contents: FSM state enum, digit limits and field widths.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } timer_state_e;

   localparam int unsigned MS_MAX  = 999;
   localparam int unsigned SEC_MAX = 59;
   localparam int unsigned MIN_MAX = 59;

   localparam int unsigned MS_W    = 10;
   localparam int unsigned SEC_W   = 6;
   localparam int unsigned MIN_W   = 6;
   localparam int unsigned PRESC_W = 16;

endpackage : timer_pkg

// File: rtl/timer_digit_dec.sv
// Modulo-(MAX+1) down counter used for one field of the timer.
// Ports:
//   clk, reset     - clock and synchronous active-low reset (value -> 0)
//   load, load_val - capture load_val, clamped to MAX
//   dec_en         - decrement by one; 0 wraps to MAX
//   value          - registered field value
//   borrow_out_c   - combinational: a decrement is wrapping this field
module timer_digit_dec #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned MAX   = 59
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec_en,
   output logic [WIDTH-1:0] value,
   output logic             borrow_out_c
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   assign borrow_out_c = dec_en && (value_q == '0);

   // Next value: clamped load, else wrap-around decrement
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = (load_val > WIDTH'(MAX)) ? WIDTH'(MAX) : load_val;
      end else if (dec_en) begin
         value_d = (value_q == '0) ? WIDTH'(MAX) : value_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule : timer_digit_dec

// File: rtl/countdown_timer.sv
// MM:SS.mmm countdown timer with load / start / stop control.
// Ports:
//   clk, reset                    - clock, synchronous active-low reset
//   load, load_min/sec/ms         - capture presets (clamped), go IDLE
//   start, stop                   - level controls; stop beats start
//   min, sec, millisec            - registered remaining time
//   running, done, expire_pulse   - registered status (RUN, EXPIRED, entry pulse)
// TICK_DIV: clk cycles per millisecond tick (1..65535).
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [5:0] load_min,
   input  logic [5:0] load_sec,
   input  logic [9:0] load_ms,
   input  logic       start,
   input  logic       stop,
   output logic [9:0] millisec,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic       running,
   output logic       done,
   output logic       expire_pulse
);

   timer_state_e       state_q, state_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               running_q, running_d;
   logic               done_q, done_d;
   logic               expire_pulse_q, expire_pulse_d;

   logic [MS_W-1:0]    ms_val;
   logic [SEC_W-1:0]   sec_val;
   logic [MIN_W-1:0]   min_val;
   logic               tick_c;
   logic               ms_borrow_c;
   logic               sec_borrow_c;
   logic               min_borrow_c;
   logic               count_nz_c;
   logic               last_ms_c;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   // A tick only happens in RUN when neither load nor stop takes the edge
   assign tick_c     = (state_q == ST_RUN) && !load && !stop && (presc_q == PRESC_LAST);
   assign count_nz_c = |{min_val, sec_val, ms_val};
   assign last_ms_c  = (ms_val == MS_W'(1)) && (sec_val == '0) && (min_val == '0);

   timer_digit_dec #(.WIDTH(MS_W), .MAX(MS_MAX)) u_ms (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .load_val     (load_ms),
      .dec_en       (tick_c),
      .value        (ms_val),
      .borrow_out_c (ms_borrow_c)
   );

   timer_digit_dec #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .load_val     (load_sec),
      .dec_en       (ms_borrow_c),
      .value        (sec_val),
      .borrow_out_c (sec_borrow_c)
   );

   timer_digit_dec #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
      .clk          (clk),
      .reset        (reset),
      .load         (load),
      .load_val     (load_min),
      .dec_en       (sec_borrow_c),
      .value        (min_val),
      .borrow_out_c (min_borrow_c)
   );

   // Next-state, prescaler and status outputs
   always_comb begin
      state_d        = state_q;
      presc_d        = presc_q;
      expire_pulse_d = 1'b0;
      if (load) begin
         state_d = ST_IDLE;
         presc_d = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !stop && count_nz_c) state_d = ST_RUN;
            end
            ST_RUN: begin
               if (stop) begin
                  state_d = ST_PAUSE;
               end else if (tick_c) begin
                  presc_d = '0;
                  // min borrow means the count was already zero; park it anyway
                  if (last_ms_c || min_borrow_c) begin
                     state_d        = ST_EXPIRED;
                     expire_pulse_d = 1'b1;
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end
            ST_PAUSE: begin
               if (start && !stop) state_d = ST_RUN;
            end
            ST_EXPIRED: state_d = ST_EXPIRED;
            default:    state_d = ST_IDLE;
         endcase
      end
      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_EXPIRED);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= ST_IDLE;
         presc_q        <= '0;
         running_q      <= 1'b0;
         done_q         <= 1'b0;
         expire_pulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         running_q      <= running_d;
         done_q         <= done_d;
         expire_pulse_q <= expire_pulse_d;
      end
   end

   assign millisec     = ms_val;
   assign sec          = sec_val;
   assign min          = min_val;
   assign running      = running_q;
   assign done         = done_q;
   assign expire_pulse = expire_pulse_q;

endmodule : countdown_timer
